serial_recv_align: RTL and testbench

Parametrised successor to the single-lane LVDS receiver. It takes already-captured 2-bit DDR sample pairs for `LANES` independent lanes, all on the serial clock. Each lane runs its own HUNT/CHECK/LOCK state machine that finds the word boundary by searching for a sync word at any bit offset. Once locked, each lane emits aligned `WORD_W`-bit words with a per-lane valid strobe. It replaces the fixed 64-bit, boundary-by-external-clock capture path and sits between the IDDR2 primitives and the link-layer framer.

---
 rtl/serial_recv_pkg.sv | 25 ++
 rtl/serial_recv_lane.sv | 162 ++++++++++++++++
 rtl/serial_recv_align.sv | 49 ++++
 tb/tb_serial_recv_align.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_recv_pkg.sv
// -----------------------------------------------------------------------------
// serial_recv_pkg
// Shared types and constants for the multi-lane serial receive aligner.
//   lane_st_t     : per-lane alignment state (HUNT / CHECK / LOCK)
//   SYNC_DEFAULT  : default sync/idle word; lanes use its low WORD_W bits
//   GOOD_W        : width of the consecutive-sync counter
// Optional feature macro used by the lane: SERIAL_RECV_IDLE_DROP_EN
// -----------------------------------------------------------------------------
package serial_recv_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } lane_st_t;

    localparam logic [63:0] SYNC_DEFAULT = 64'hA5C3_5A3C_F00F_0FF0;
    localparam int          GOOD_W       = 4;

    // Saturation-free increment of the sync counter; LOCK_CNT <= 15 keeps it in range.
    function automatic logic [GOOD_W-1:0] good_inc(input logic [GOOD_W-1:0] g);
        return g + {{(GOOD_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/serial_recv_lane.sv
// -----------------------------------------------------------------------------
// serial_recv_lane
// One serial lane: shifts in 2-bit DDR pairs, hunts for the sync word at an
// even or odd bit offset, confirms it over LOCK_CNT consecutive words, then
// emits aligned words once per WORD_W/2 cycles.
// Ports:
//   CLKS    in   serial clock
//   RSTS    in   synchronous active-high reset
//   RELOCK  in   synchronous pulse, forces the lane back to HUNT
//   DDR     in   [1:0] sample pair, DDR[1] is the earlier serial bit
//   DOUT    out  [WORD_W-1:0] aligned word, MSB is the earliest bit
//   DVALID  out  one-cycle strobe when DOUT is new
//   LOCKED  out  lane is in LOCK
// Macro SERIAL_RECV_IDLE_DROP_EN: in LOCK, sync words are treated as idle
// (no strobe, DOUT holds). Undefined: every LOCK word is emitted.
// -----------------------------------------------------------------------------
module serial_recv_lane
    import serial_recv_pkg::*;
#(
    parameter int                WORD_W   = 64,
    parameter logic [WORD_W-1:0] SYNC     = SYNC_DEFAULT[WORD_W-1:0],
    parameter int                LOCK_CNT = 4
) (
    input  logic              CLKS,
    input  logic              RSTS,
    input  logic              RELOCK,
    input  logic [1:0]        DDR,
    output logic [WORD_W-1:0] DOUT,
    output logic              DVALID,
    output logic              LOCKED
);

    localparam int                HALF      = WORD_W / 2;
    localparam int                PH_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HALF - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

    logic [WORD_W:0]     sh_r;
    logic [PH_W-1:0]     ph_r;
    logic                off_r;
    logic [GOOD_W-1:0]   good_r;
    lane_st_t            st_r;
    logic [WORD_W-1:0]   dout_r;
    logic                dvalid_r;
    logic                locked_r;

    logic                even_hit_s;
    logic                odd_hit_s;
    logic                boundary_s;
    logic [WORD_W-1:0]   word_s;
    logic                word_sync_s;
    logic [PH_W-1:0]     ph_next_s;
    logic [GOOD_W-1:0]   good_next_s;

    // Window compare and boundary decode on the already-shifted register.
    always_comb begin
        even_hit_s  = (sh_r[WORD_W-1:0] == SYNC);
        odd_hit_s   = (sh_r[WORD_W:1]   == SYNC);
        boundary_s  = (ph_r == PH_LAST);
        if (off_r) begin
            word_s = sh_r[WORD_W:1];
        end else begin
            word_s = sh_r[WORD_W-1:0];
        end
        word_sync_s = (word_s == SYNC);
        // Explicit wrap so non-power-of-two WORD_W/2 works.
        if (boundary_s) begin
            ph_next_s = {PH_W{1'b0}};
        end else begin
            ph_next_s = ph_r + {{(PH_W-1){1'b0}}, 1'b1};
        end
        good_next_s = good_inc(good_r);
    end

    // Shift register, alignment FSM and registered outputs.
    always_ff @(posedge CLKS) begin
        if (RSTS) begin
            sh_r     <= {(WORD_W+1){1'b0}};
            ph_r     <= {PH_W{1'b0}};
            off_r    <= 1'b0;
            good_r   <= {GOOD_W{1'b0}};
            st_r     <= HUNT;
            dout_r   <= {WORD_W{1'b0}};
            dvalid_r <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            sh_r     <= {sh_r[WORD_W-2:0], DDR};
            dvalid_r <= 1'b0;
            if (RELOCK) begin
                // DOUT deliberately holds; only RSTS clears it.
                st_r     <= HUNT;
                good_r   <= {GOOD_W{1'b0}};
                locked_r <= 1'b0;
            end else begin
                case (st_r)
                    HUNT: begin
                        if (even_hit_s || odd_hit_s) begin
                            off_r  <= ~even_hit_s;  // even wins a tie
                            ph_r   <= {PH_W{1'b0}};
                            good_r <= {{(GOOD_W-1){1'b0}}, 1'b1};
                            if (LOCK_CNT == 1) begin
                                st_r     <= LOCK;
                                locked_r <= 1'b1;
                            end else begin
                                st_r <= CHECK;
                            end
                        end else begin
                            st_r <= HUNT;
                        end
                    end
                    CHECK: begin
                        ph_r <= ph_next_s;
                        if (boundary_s) begin
                            if (word_sync_s) begin
                                good_r <= good_next_s;
                                if (good_next_s == GOOD_LOCK) begin
                                    st_r     <= LOCK;
                                    locked_r <= 1'b1;
                                end else begin
                                    st_r <= CHECK;
                                end
                            end else begin
                                st_r   <= HUNT;
                                good_r <= {GOOD_W{1'b0}};
                            end
                        end else begin
                            st_r <= CHECK;
                        end
                    end
                    LOCK: begin
                        ph_r <= ph_next_s;
                        if (boundary_s) begin
`ifdef SERIAL_RECV_IDLE_DROP_EN
                            if (!word_sync_s) begin
                                dout_r   <= word_s;
                                dvalid_r <= 1'b1;
                            end else begin
                                dout_r <= dout_r;
                            end
`else
                            dout_r   <= word_s;
                            dvalid_r <= 1'b1;
`endif
                        end else begin
                            dout_r <= dout_r;
                        end
                    end
                    default: begin
                        st_r     <= HUNT;
                        good_r   <= {GOOD_W{1'b0}};
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DOUT   = dout_r;
    assign DVALID = dvalid_r;
    assign LOCKED = locked_r;

endmodule

// File: rtl/serial_recv_align.sv
// -----------------------------------------------------------------------------
// serial_recv_align
// Multi-lane word aligner between the DDR input capture and the link framer.
// Each lane independently finds the sync word and emits aligned words; there
// is no inter-lane deskew.
// Ports:
//   CLKS    in   serial clock (only clock)
//   RSTS    in   synchronous active-high reset
//   DDR     in   [2*LANES-1:0], lane l pair DDR[2l+1:2l], bit 2l+1 earlier
//   RELOCK  in   synchronous pulse, all lanes back to HUNT
//   DOUT    out  [LANES*WORD_W-1:0], lane l word DOUT[l*WORD_W +: WORD_W]
//   DVALID  out  [LANES-1:0] per-lane new-word strobe
//   LOCKED  out  [LANES-1:0] per-lane lock status
// Macro SERIAL_RECV_IDLE_DROP_EN (optional): suppress sync words in LOCK.
// -----------------------------------------------------------------------------
module serial_recv_align
    import serial_recv_pkg::*;
#(
    parameter int          LANES    = 1,
    parameter int          WORD_W   = 64,
    parameter logic [63:0] SYNC     = SYNC_DEFAULT,
    parameter int          LOCK_CNT = 4
) (
    input  logic                      CLKS,
    input  logic                      RSTS,
    input  logic [2*LANES-1:0]        DDR,
    input  logic                      RELOCK,
    output logic [LANES*WORD_W-1:0]   DOUT,
    output logic [LANES-1:0]          DVALID,
    output logic [LANES-1:0]          LOCKED
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        serial_recv_lane #(
            .WORD_W   (WORD_W),
            .SYNC     (SYNC[WORD_W-1:0]),
            .LOCK_CNT (LOCK_CNT)
        ) u_lane (
            .CLKS   (CLKS),
            .RSTS   (RSTS),
            .RELOCK (RELOCK),
            .DDR    (DDR[2*l+1:2*l]),
            .DOUT   (DOUT[l*WORD_W +: WORD_W]),
            .DVALID (DVALID[l]),
            .LOCKED (LOCKED[l])
        );
    end

endmodule

// File: tb/tb_serial_recv_align.sv
// Bench for serial_recv_align: 2 lanes, 16-bit words, sync A5C3, lock after 3.
// The reference model works on the serial bit history of each lane: it finds
// the sync word ending at the newest or second-newest bit and then takes one
// word every 16 bits from that absolute bit position.
module tb_serial_recv_align;

    localparam int          LANES    = 2;
    localparam int          W        = 16;
    localparam int          LOCK_CNT = 3;
    localparam int          HMAX     = 16384;
    localparam int          SMAX     = 2048;
    localparam logic [15:0] SYNC_W   = 16'hA5C3;
`ifdef SERIAL_RECV_IDLE_DROP_EN
    localparam bit IDLE_DROP = 1'b1;
`else
    localparam bit IDLE_DROP = 1'b0;
`endif

    logic                 CLKS = 1'b0;
    logic                 RSTS;
    logic                 RELOCK;
    logic [2*LANES-1:0]   DDR;
    logic [LANES*W-1:0]   DOUT;
    logic [LANES-1:0]     DVALID;
    logic [LANES-1:0]     LOCKED;

    serial_recv_align #(
        .LANES    (LANES),
        .WORD_W   (W),
        .SYNC     (64'h0000_0000_0000_A5C3),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .CLKS   (CLKS),
        .RSTS   (RSTS),
        .DDR    (DDR),
        .RELOCK (RELOCK),
        .DOUT   (DOUT),
        .DVALID (DVALID),
        .LOCKED (LOCKED)
    );

    always #5 CLKS = ~CLKS;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus bit sources
    bit src [LANES][SMAX];
    int s_head [LANES];
    int s_tail [LANES];

    // reference model
    bit          hist [LANES][HMAX];
    int          hlen [LANES];
    int          m_st [LANES];   // 0 hunt, 1 confirming, 2 locked
    int          m_good [LANES];
    int          m_bl [LANES];   // newest-bit index at which next word is taken
    int          m_off [LANES];
    logic [15:0] m_dout [LANES];
    bit          m_dv [LANES];
    bit          m_lk [LANES];

    // data-word hit counters for the table scenarios
    logic [15:0] tgt [LANES];
    int          hits [LANES];

    typedef struct {
        int          off0;
        int          off1;
        int          nsync;
        bit          corrupt;
        logic [15:0] d0;
        logic [15:0] d1;
        int          exp_hits;
        bit          exp_lock;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int l, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lane %0d cyc %0d got %h want %h", name, l, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input int l, input int e);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = hist[l][e-15+i];
        return w;
    endfunction

    function automatic bit bnd_next(input int l);
        return (m_st[l] != 0) && (hlen[l] - 1 == m_bl[l]);
    endfunction

    task automatic model_edge();
        for (int l = 0; l < LANES; l++) begin
            if (RSTS) begin
                for (int i = 0; i <= W; i++) hist[l][i] = 1'b0;
                hlen[l] = W + 1;
                m_st[l] = 0; m_good[l] = 0; m_bl[l] = 0; m_off[l] = 0;
                m_dout[l] = 16'h0000; m_dv[l] = 1'b0; m_lk[l] = 1'b0;
            end else begin
                int          last;
                logic [15:0] w;
                last    = hlen[l] - 1;
                m_dv[l] = 1'b0;
                if (RELOCK) begin
                    m_st[l] = 0; m_good[l] = 0; m_lk[l] = 1'b0;
                end else if (m_st[l] == 0) begin
                    bit hit;
                    hit = 1'b0;
                    if (word_at(l, last) == SYNC_W) begin
                        m_off[l] = 0; hit = 1'b1;
                    end else if (word_at(l, last - 1) == SYNC_W) begin
                        m_off[l] = 1; hit = 1'b1;
                    end
                    if (hit) begin
                        m_bl[l]   = last + W;
                        m_good[l] = 1;
                        if (LOCK_CNT == 1) begin m_st[l] = 2; m_lk[l] = 1'b1; end
                        else m_st[l] = 1;
                    end
                end else if (last == m_bl[l]) begin
                    w       = word_at(l, m_bl[l] - m_off[l]);
                    m_bl[l] = m_bl[l] + W;
                    if (m_st[l] == 1) begin
                        if (w == SYNC_W) begin
                            m_good[l]++;
                            if (m_good[l] == LOCK_CNT) begin m_st[l] = 2; m_lk[l] = 1'b1; end
                        end else begin
                            m_st[l] = 0; m_good[l] = 0;
                        end
                    end else if (!(IDLE_DROP && w == SYNC_W)) begin
                        m_dout[l] = w; m_dv[l] = 1'b1;
                    end
                end
                if (hlen[l] + 2 > HMAX) begin
                    $display("FAIL history_overflow lane %0d got %0d want <%0d", l, hlen[l], HMAX);
                    $fatal(1);
                end
                hist[l][hlen[l]]     = DDR[2*l+1];
                hist[l][hlen[l] + 1] = DDR[2*l];
                hlen[l] += 2;
            end
        end
    endtask

    task automatic step();
        logic [2*LANES-1:0] v;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 1; b >= 0; b--) begin
                if (s_head[l] < s_tail[l]) begin
                    v[2*l+b] = src[l][s_head[l]];
                    s_head[l]++;
                end else begin
                    v[2*l+b] = 1'b0;
                end
            end
        end
        DDR = v;
        @(posedge CLKS);
        model_edge();
        @(negedge CLKS);
        cyc++;
        for (int l = 0; l < LANES; l++) begin
            chk("dout",   l, 32'(DOUT[l*W +: W]), 32'(m_dout[l]));
            chk("dvalid", l, 32'(DVALID[l]),      32'(m_dv[l]));
            chk("locked", l, 32'(LOCKED[l]),      32'(m_lk[l]));
            if (DVALID[l] && DOUT[l*W +: W] == tgt[l]) hits[l]++;
        end
    endtask

    task automatic push_bits(input int l, input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            src[l][s_tail[l]] = w[i];
            s_tail[l]++;
        end
    endtask

    task automatic clear_src();
        for (int l = 0; l < LANES; l++) begin s_head[l] = 0; s_tail[l] = 0; end
    endtask

    task automatic relock_pulse();
        RELOCK = 1'b1; step(); RELOCK = 1'b0;
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == SYNC_W || w == 16'h0000) w = 16'h5A5A;
        return w;
    endfunction

    task automatic drain(input int extra);
        int k;
        k = 0;
        while ((s_head[0] < s_tail[0] || s_head[1] < s_tail[1]) && k < 600) begin
            step(); k++;
        end
        chk("drain", 0, 32'(k < 600), 32'd1);
        for (int i = 0; i < extra; i++) step();
    endtask

    initial begin
        RSTS = 1'b1; RELOCK = 1'b0; DDR = '0;
        clear_src();
        tgt[0] = 16'h0000; tgt[1] = 16'h0000; hits[0] = 0; hits[1] = 0;

        // reset state
        step(); step();
        RSTS = 1'b0;
        chk("rst_dout",   0, 32'(DOUT),   32'd0);
        chk("rst_dvalid", 0, 32'(DVALID), 32'd0);
        chk("rst_locked", 0, 32'(LOCKED), 32'd0);

        // table: offsets, sync count, corruption, data, expected outcome
        vecs[0] = '{0, 5, 3, 1'b0, 16'h1234, 16'hBEEF, 1, 1'b1};
        vecs[1] = '{1, 0, 3, 1'b0, 16'h1234, 16'h0F0F, 1, 1'b1};
        vecs[2] = '{0, 1, 2, 1'b0, 16'h1234, 16'h4321, 0, 1'b0};
        vecs[3] = '{0, 3, 2, 1'b1, 16'hCAFE, 16'h1357, 1, 1'b1};
        vecs[4] = '{7, 12, 5, 1'b0, 16'h00FF, 16'h8001, 1, 1'b1};
        vecs[5] = '{3, 2, 1, 1'b0, 16'h7777, 16'h2468, 0, 1'b0};
        for (int v = 0; v < 6; v++) begin
            relock_pulse();
            clear_src();
            tgt[0] = vecs[v].d0; tgt[1] = vecs[v].d1;
            hits[0] = 0; hits[1] = 0;
            for (int l = 0; l < LANES; l++) begin
                push_bits(l, 16'h0000, (l == 0) ? vecs[v].off0 : vecs[v].off1);
                for (int s = 0; s < vecs[v].nsync; s++) push_bits(l, SYNC_W, 16);
                if (vecs[v].corrupt) begin
                    push_bits(l, 16'hA5C2, 16);
                    for (int s = 0; s < 3; s++) push_bits(l, SYNC_W, 16);
                end
                push_bits(l, (l == 0) ? vecs[v].d0 : vecs[v].d1, 16);
                push_bits(l, 16'h0000, 16);
            end
            drain(12);
            for (int l = 0; l < LANES; l++) begin
                chk("tbl_hits", l, 32'(hits[l]), 32'(vecs[v].exp_hits));
                chk("tbl_lock", l, 32'(LOCKED[l]), 32'(vecs[v].exp_lock));
            end
        end

        // strobe period in LOCK, then RELOCK on a boundary cycle
        begin
            int          last_dv;
            int          nstr;
            bit          found;
            logic [15:0] held;
            relock_pulse();
            clear_src();
            tgt[0] = 16'h1234; tgt[1] = 16'h1234; hits[0] = 0; hits[1] = 0;
            for (int s = 0; s < 3; s++) push_bits(0, SYNC_W, 16);
            for (int s = 0; s < 8; s++) push_bits(0, rand_data(), 16);
            last_dv = -1; nstr = 0; found = 1'b0;
            for (int k = 0; k < 90 && !found; k++) begin
                step();
                if (DVALID[0]) begin
                    if (last_dv >= 0) chk("period", 0, 32'(cyc - last_dv), 32'd8);
                    last_dv = cyc;
                    nstr++;
                end
                if (nstr >= 3 && m_st[0] == 2 && bnd_next(0)) found = 1'b1;
            end
            chk("bnd_found", 0, 32'(found), 32'd1);
            held = DOUT[15:0];
            relock_pulse();
            chk("relock_dvalid", 0, 32'(DVALID[0]),  32'd0);
            chk("relock_locked", 0, 32'(LOCKED[0]),  32'd0);
            chk("relock_hold",   0, 32'(DOUT[15:0]), 32'(held));
            for (int s = 0; s < 3; s++) push_bits(0, SYNC_W, 16);
            push_bits(0, 16'h1234, 16);
            drain(10);
            chk("relock_again", 0, 32'(hits[0]), 32'd1);
        end

        // randomized streams against the model
        for (int r = 0; r < 12; r++) begin
            relock_pulse();
            clear_src();
            for (int l = 0; l < LANES; l++) begin
                int off;
                off = $urandom_range(0, 15);
                for (int i = 0; i < off; i++) push_bits(l, 16'($urandom_range(0, 1)), 1);
                for (int s = 0; s < 3; s++) push_bits(l, SYNC_W, 16);
                for (int k = 0; k < 6; k++) begin
                    if ($urandom_range(0, 2) == 0) push_bits(l, SYNC_W, 16);
                    else push_bits(l, rand_data(), 16);
                end
            end
            for (int k = 0; k < 100; k++) begin
                if (k == 50 && (r % 4) == 3) RELOCK = 1'b1;
                step();
                RELOCK = 1'b0;
            end
        end

        // RSTS in the middle of a locked stream
        relock_pulse();
        clear_src();
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < 4; s++) push_bits(l, SYNC_W, 16);
            for (int s = 0; s < 6; s++) push_bits(l, rand_data(), 16);
        end
        for (int k = 0; k < 52; k++) step();
        chk("pre_rst_locked", 0, 32'(LOCKED), 32'd3);
        RSTS = 1'b1; step(); RSTS = 1'b0;
        chk("midrst_dout",   0, 32'(DOUT),   32'd0);
        chk("midrst_dvalid", 0, 32'(DVALID), 32'd0);
        chk("midrst_locked", 0, 32'(LOCKED), 32'd0);
        for (int k = 0; k < 20; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
